spi_master: RTL and testbench

//  SPI mode-0 master that drives the SAR ADC's SPI control slave (sck/mosi/ss in, miso out).

---
 rtl/spi_master.sv | 137 +++++++++++++
 tb/tb_spi_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts tx_data out MSB-first on mosi, captures miso into rx_data.
// done fires (2*DATA_W+1)*CLK_DIV clocks after an accepted start; start while busy is dropped, never queued.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  output logic              ss,
  input  logic              miso
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt, div_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              sck_nxt, mosi_nxt, ss_nxt, busy_nxt, done_nxt;
  logic              phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      ss      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      rx_data <= rx_data_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
      ss      <= ss_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    rx_data_nxt = rx_data;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    ss_nxt      = ss;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    // Every non-idle state lasts exactly CLK_DIV clocks.
    if (state != IDLE) div_cnt_nxt = phase_end ? '0 : div_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          tx_sh_nxt   = tx_data;
          ss_nxt      = 1'b0;
          mosi_nxt    = tx_data[DATA_W-1];
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
          state_nxt   = LEAD;
        end
      end
      LEAD: begin
        if (phase_end) begin
          sck_nxt   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_nxt     = 1'b0;
          rx_sh_nxt   = {rx_sh[DATA_W-2:0], miso};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = TRAIL;
          end else begin
            tx_sh_nxt = tx_sh << 1;
            mosi_nxt  = tx_sh[DATA_W-2];
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          sck_nxt   = 1'b1;
          state_nxt = HIGH;
        end
      end
      TRAIL: begin
        if (phase_end) begin
          ss_nxt      = 1'b1;
          done_nxt    = 1'b1;
          rx_data_nxt = rx_sh;
          mosi_nxt    = 1'b0;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (phase_end) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance at CLK_DIV=1 and one at CLK_DIV=4, muxed through a common observer.
module tb_spi_master;
  logic       clk, rst, start, sel, loop, miso_drv;
  logic [7:0] tx_data;
  logic       start1, start4, miso1, miso4, miso_eff;
  logic       busy1, done1, sck1, mosi1, ss1, busy4, done4, sck4, mosi4, ss4;
  logic [7:0] rx1, rx4;
  logic       o_sck, o_mosi, o_ss, o_busy, o_done;
  logic [7:0] o_rx;

  int vectors, miscompares;
  int m_rises, m_hi_min, m_hi_max, hi_len, m_ss_low, m_done_cnt, m_done_idx, m_busy_fall, nfall;
  logic [7:0] m_mosi, m_rx, rep;

  typedef struct {
    bit         s;
    logic [7:0] tx;
    logic [7:0] reply;
    bit         lb;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl[5];

  assign start1   = start & ~sel;
  assign start4   = start & sel;
  assign o_sck    = sel ? sck4  : sck1;
  assign o_mosi   = sel ? mosi4 : mosi1;
  assign o_ss     = sel ? ss4   : ss1;
  assign o_busy   = sel ? busy4 : busy1;
  assign o_done   = sel ? done4 : done1;
  assign o_rx     = sel ? rx4   : rx1;
  assign miso_eff = loop ? o_mosi : miso_drv;
  assign miso1    = sel ? 1'b0 : miso_eff;
  assign miso4    = sel ? miso_eff : 1'b0;

  spi_master #(.DATA_W(8), .CLK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data), .busy(busy1), .done(done1),
    .rx_data(rx1), .sck(sck1), .mosi(mosi1), .ss(ss1), .miso(miso1));
  spi_master #(.DATA_W(8), .CLK_DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .tx_data(tx_data), .busy(busy4), .done(done4),
    .rx_data(rx4), .sck(sck4), .mosi(mosi4), .ss(ss4), .miso(miso4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transfer on the selected instance and records what the SPI pins did.
  task automatic run_xfer(input bit s, input logic [7:0] tx, input logic [7:0] reply,
                          input bit lb, input int ign_at);
    int d;
    logic prev_sck, prev_busy;
    d = s ? 4 : 1;
    sel = s; loop = lb; rep = reply; nfall = 0; miso_drv = reply[7];
    m_rises = 0; m_mosi = '0; m_hi_min = 999; m_hi_max = 0; hi_len = 0; m_ss_low = 0;
    m_done_cnt = 0; m_done_idx = -1; m_busy_fall = -1; m_rx = '0;
    @(negedge clk);
    start = 1'b1; tx_data = tx;
    prev_sck = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < 18 * d + 4; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; tx_data = ~tx; end
      if (i == ign_at) begin start = 1'b1; tx_data = 8'hFF; end
      else if (i == ign_at + 1) start = 1'b0;
      if (o_sck && !prev_sck) begin
        m_rises++; m_mosi = {m_mosi[6:0], o_mosi}; hi_len = 1;
      end else if (o_sck) begin
        hi_len++;
      end
      if (!o_sck && prev_sck) begin
        if (hi_len < m_hi_min) m_hi_min = hi_len;
        if (hi_len > m_hi_max) m_hi_max = hi_len;
        nfall++;
        miso_drv = (nfall < 8) ? rep[7 - nfall] : 1'b0;
      end
      if (!o_ss) m_ss_low++;
      if (o_done) begin m_done_cnt++; m_done_idx = i; m_rx = o_rx; end
      if (prev_busy && !o_busy) m_busy_fall = i;
      prev_sck = o_sck; prev_busy = o_busy;
    end
  endtask

  task automatic check_xfer(input string tag, input int d, input logic [7:0] exp_mosi,
                            input logic [7:0] exp_rx);
    check({tag, "_rises"},     m_rises, 8);
    check({tag, "_mosi"},      m_mosi, exp_mosi);
    check({tag, "_hi_min"},    m_hi_min, d);
    check({tag, "_hi_max"},    m_hi_max, d);
    check({tag, "_ss_low"},    m_ss_low, (2 * 8 + 1) * d);
    check({tag, "_done_cnt"},  m_done_cnt, 1);
    check({tag, "_done_at"},   m_done_idx, (2 * 8 + 1) * d);
    check({tag, "_rx"},        m_rx, exp_rx);
    check({tag, "_busy_tail"}, m_busy_fall - m_done_idx, d);
    check({tag, "_idle_pins"}, {o_ss, o_sck, o_mosi}, 3'b100);
  endtask

  initial begin
    int rc, hrun, gaps, dcnt, lowcnt;
    logic prev, prev_ss, seen_low;
    logic [7:0] rtx, rrep, rexp;
    bit rs, rlb;
    vectors = 0; miscompares = 0;
    rst = 1'b0; start = 1'b0; sel = 1'b0; loop = 1'b0; miso_drv = 1'b0; tx_data = '0;

    tbl[0] = '{1'b0, 8'h40, 8'hA5, 1'b0, 8'h40, 8'hA5};
    tbl[1] = '{1'b1, 8'hC3, 8'h3C, 1'b0, 8'hC3, 8'h3C};
    tbl[2] = '{1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF};
    tbl[4] = '{1'b1, 8'h81, 8'h00, 1'b1, 8'h81, 8'h81};

    // Reset held with start toggling on both instances.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_d1", {ss1, sck1, mosi1, busy1, done1, rx1}, 13'h1000);
      check("reset_d4", {ss4, sck4, mosi4, busy4, done4, rx4}, 13'h1000);
      start = i[0]; sel = i[1]; tx_data = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_xfer(tbl[k].s, tbl[k].tx, tbl[k].reply, tbl[k].lb, -10);
      check_xfer($sformatf("tbl%0d", k), tbl[k].s ? 4 : 1, tbl[k].exp_mosi, tbl[k].exp_rx);
    end

    // Second start 5 clocks into a transfer must be ignored.
    run_xfer(1'b1, 8'h3C, 8'h99, 1'b0, 5);
    check_xfer("ignore", 4, 8'h3C, 8'h99);

    // Reset pulled after the third sck rise.
    sel = 1'b1; loop = 1'b0; miso_drv = 1'b1;
    @(negedge clk); start = 1'b1; tx_data = 8'h96;
    @(negedge clk); start = 1'b0;
    rc = 0; prev = 1'b0;
    for (int i = 0; i < 100 && rc < 3; i++) begin
      @(negedge clk);
      if (o_sck && !prev) rc++;
      prev = o_sck;
    end
    check("abort_rise3", rc, 3);
    rst = 1'b0; #1;
    check("abort_d4", {ss4, sck4, mosi4, busy4, done4, rx4}, 13'h1000);
    check("abort_d1", {ss1, sck1, mosi1, busy1, done1, rx1}, 13'h1000);
    @(negedge clk); rst = 1'b1;
    dcnt = 0; lowcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done4 || done1) dcnt++;
      if (!ss4) lowcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_ss_high", lowcnt, 0);
    run_xfer(1'b1, 8'h5A, 8'hC6, 1'b0, -10);
    check_xfer("post_abort", 4, 8'h5A, 8'hC6);

    // Start held high: back-to-back transfers with a CLK_DIV+1 deselect gap.
    sel = 1'b1; loop = 1'b0; miso_drv = 1'b0;
    @(negedge clk); start = 1'b1; tx_data = 8'h33;
    prev_ss = 1'b1; hrun = 0; gaps = 0; seen_low = 1'b0; dcnt = 0;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (i == 199) start = 1'b0;
      if (o_done) dcnt++;
      if (o_ss) begin
        hrun++;
      end else begin
        if (prev_ss && seen_low) begin check("b2b_gap", hrun, 5); gaps++; end
        seen_low = 1'b1; hrun = 0;
      end
      prev_ss = o_ss;
    end
    check("b2b_gaps", gaps, 2);
    check("b2b_dones", dcnt, 3);

    // Randomized transfers against the behavioural expectation.
    for (int k = 0; k < 12; k++) begin
      rs = 1'($urandom_range(0, 1)); rlb = 1'($urandom_range(0, 1));
      rtx = 8'($urandom); rrep = 8'($urandom);
      rexp = rlb ? rtx : rrep;
      run_xfer(rs, rtx, rrep, rlb, -10);
      check_xfer($sformatf("rnd%0d", k), rs ? 4 : 1, rtx, rexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
